// File: rtl/ro_buffer.sv
// Reorder buffer, tags 1..15: retires in order with registered commit/store/flush pulses (ready head -> outputs after next edge); issuer must honour full_to_issuer, rdy low freezes all state.
// Optional ROB_CDB_BYPASS_EN: operand lookups also see the CDB broadcast of the same cycle.
module ro_buffer #(
    parameter int ROB_ID_W = 4,
    parameter int XLEN     = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                rdy,
    input  logic                issue_valid_from_issuer,
    input  logic [4:0]          rd_from_issuer,
    input  logic                is_branch_from_issuer,
    input  logic                is_store_from_issuer,
    input  logic                pred_taken_from_issuer,
    input  logic [XLEN-1:0]     pc_from_issuer,
    output logic [ROB_ID_W-1:0] dest_to_issuer,
    output logic                full_to_issuer,
    input  logic                cdb_valid,
    input  logic [ROB_ID_W-1:0] cdb_dest,
    input  logic [XLEN-1:0]     cdb_value,
    input  logic                cdb_taken,
    input  logic [XLEN-1:0]     cdb_target,
    input  logic [ROB_ID_W-1:0] qj_from_rs,
    input  logic [ROB_ID_W-1:0] qk_from_rs,
    output logic                ready_j,
    output logic                ready_k,
    output logic [XLEN-1:0]     value_j,
    output logic [XLEN-1:0]     value_k,
    output logic [4:0]          rd_to_reg_file,
    output logic [ROB_ID_W-1:0] dest_to_reg_file,
    output logic [XLEN-1:0]     value_to_reg_file,
    output logic                store_commit_to_lsb,
    output logic [ROB_ID_W-1:0] store_dest_to_lsb,
    output logic                reset_to_rob_bus,
    output logic [XLEN-1:0]     pc_to_fetcher
);
    localparam int DEPTH = 1 << ROB_ID_W;
    localparam logic [ROB_ID_W-1:0] LAST_TAG  = ROB_ID_W'(DEPTH - 1);
    localparam logic [ROB_ID_W-1:0] FIRST_TAG = ROB_ID_W'(1);

    logic                busy_q    [DEPTH];
    logic                ready_q   [DEPTH];
    logic [4:0]          rd_q      [DEPTH];
    logic [XLEN-1:0]     value_q   [DEPTH];
    logic                branch_q  [DEPTH];
    logic                store_q   [DEPTH];
    logic                pred_q    [DEPTH];
    logic                taken_q   [DEPTH];
    logic [XLEN-1:0]     target_q  [DEPTH];
    logic [XLEN-1:0]     pc_q      [DEPTH];
    logic [ROB_ID_W-1:0] head_q, head_d, tail_q, tail_d, count_q, count_d;
    logic                do_issue, do_commit;

    assign full_to_issuer = (count_q == LAST_TAG);
    assign dest_to_issuer = tail_q;
    // Nothing enters or leaves while the flush pulse is out; the whole window is discarded next edge.
    assign do_issue  = issue_valid_from_issuer && !full_to_issuer && !reset_to_rob_bus;
    assign do_commit = busy_q[head_q] && ready_q[head_q] && !reset_to_rob_bus;

    always_comb begin
        head_d  = do_commit ? ((head_q == LAST_TAG) ? FIRST_TAG : head_q + 1'b1) : head_q;
        tail_d  = do_issue  ? ((tail_q == LAST_TAG) ? FIRST_TAG : tail_q + 1'b1) : tail_q;
        count_d = count_q;
        if (do_issue && !do_commit)
            count_d = count_q + 1'b1;
        else if (!do_issue && do_commit)
            count_d = count_q - 1'b1;
    end

    always_comb begin
        ready_j = 1'b1;
        value_j = '0;
        if (qj_from_rs != '0) begin
            ready_j = ready_q[qj_from_rs];
            value_j = value_q[qj_from_rs];
`ifdef ROB_CDB_BYPASS_EN
            if (cdb_valid && cdb_dest == qj_from_rs) begin
                ready_j = 1'b1;
                value_j = cdb_value;
            end
`endif
        end
    end

    always_comb begin
        ready_k = 1'b1;
        value_k = '0;
        if (qk_from_rs != '0) begin
            ready_k = ready_q[qk_from_rs];
            value_k = value_q[qk_from_rs];
`ifdef ROB_CDB_BYPASS_EN
            if (cdb_valid && cdb_dest == qk_from_rs) begin
                ready_k = 1'b1;
                value_k = cdb_value;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q              <= FIRST_TAG;
            tail_q              <= FIRST_TAG;
            count_q             <= '0;
            rd_to_reg_file      <= '0;
            dest_to_reg_file    <= '0;
            value_to_reg_file   <= '0;
            store_commit_to_lsb <= 1'b0;
            store_dest_to_lsb   <= '0;
            reset_to_rob_bus    <= 1'b0;
            pc_to_fetcher       <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                busy_q[i]   <= 1'b0;
                ready_q[i]  <= 1'b0;
                rd_q[i]     <= '0;
                value_q[i]  <= '0;
                branch_q[i] <= 1'b0;
                store_q[i]  <= 1'b0;
                pred_q[i]   <= 1'b0;
                taken_q[i]  <= 1'b0;
                target_q[i] <= '0;
                pc_q[i]     <= '0;
            end
        end else if (rdy) begin
            rd_to_reg_file      <= '0;
            dest_to_reg_file    <= '0;
            value_to_reg_file   <= '0;
            store_commit_to_lsb <= 1'b0;
            store_dest_to_lsb   <= '0;
            reset_to_rob_bus    <= 1'b0;
            if (reset_to_rob_bus) begin
                head_q  <= FIRST_TAG;
                tail_q  <= FIRST_TAG;
                count_q <= '0;
                for (int i = 0; i < DEPTH; i++)
                    busy_q[i] <= 1'b0;
            end else begin
                if (cdb_valid && cdb_dest != '0 && busy_q[cdb_dest]) begin
                    value_q[cdb_dest]  <= cdb_value;
                    taken_q[cdb_dest]  <= cdb_taken;
                    target_q[cdb_dest] <= cdb_target;
                    ready_q[cdb_dest]  <= 1'b1;
                end
                if (do_commit) begin
                    busy_q[head_q] <= 1'b0;
                    if (store_q[head_q]) begin
                        store_commit_to_lsb <= 1'b1;
                        store_dest_to_lsb   <= head_q;
                    end else begin
                        // Branches with a destination are JAL/JALR: the link value is pc+4.
                        rd_to_reg_file    <= rd_q[head_q];
                        dest_to_reg_file  <= head_q;
                        value_to_reg_file <= branch_q[head_q] ? pc_q[head_q] + XLEN'(4) : value_q[head_q];
                    end
                    if (branch_q[head_q] && (taken_q[head_q] != pred_q[head_q])) begin
                        reset_to_rob_bus <= 1'b1;
                        pc_to_fetcher    <= taken_q[head_q] ? target_q[head_q] : pc_q[head_q] + XLEN'(4);
                    end
                end
                if (do_issue) begin
                    busy_q[tail_q]   <= 1'b1;
                    ready_q[tail_q]  <= is_store_from_issuer;
                    rd_q[tail_q]     <= rd_from_issuer;
                    branch_q[tail_q] <= is_branch_from_issuer;
                    store_q[tail_q]  <= is_store_from_issuer;
                    pred_q[tail_q]   <= pred_taken_from_issuer;
                    taken_q[tail_q]  <= 1'b0;
                    pc_q[tail_q]     <= pc_from_issuer;
                end
                head_q  <= head_d;
                tail_q  <= tail_d;
                count_q <= count_d;
            end
        end
    end
endmodule

// File: tb/tb_ro_buffer.sv
// Scoreboard bench for ro_buffer: expected commits queued at issue, observed commits captured by a monitor.
module tb_ro_buffer;
    localparam int W = 4;
    localparam int XLEN = 32;

    typedef struct packed {
        logic [4:0]      rd;
        logic [W-1:0]    tag;
        logic [XLEN-1:0] val;
    } commit_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            rdy = 1'b1;
    logic            issue_valid_from_issuer = 1'b0;
    logic [4:0]      rd_from_issuer = '0;
    logic            is_branch_from_issuer = 1'b0;
    logic            is_store_from_issuer = 1'b0;
    logic            pred_taken_from_issuer = 1'b0;
    logic [XLEN-1:0] pc_from_issuer = '0;
    logic [W-1:0]    dest_to_issuer;
    logic            full_to_issuer;
    logic            cdb_valid = 1'b0;
    logic [W-1:0]    cdb_dest = '0;
    logic [XLEN-1:0] cdb_value = '0;
    logic            cdb_taken = 1'b0;
    logic [XLEN-1:0] cdb_target = '0;
    logic [W-1:0]    qj_from_rs = '0;
    logic [W-1:0]    qk_from_rs = '0;
    logic            ready_j, ready_k;
    logic [XLEN-1:0] value_j, value_k;
    logic [4:0]      rd_to_reg_file;
    logic [W-1:0]    dest_to_reg_file;
    logic [XLEN-1:0] value_to_reg_file;
    logic            store_commit_to_lsb;
    logic [W-1:0]    store_dest_to_lsb;
    logic            reset_to_rob_bus;
    logic [XLEN-1:0] pc_to_fetcher;

    int checks = 0;
    int errors = 0;
    commit_t exp_q[$];
    commit_t obs_q[$];
    logic [W-1:0]    st_q[$];
    logic [XLEN-1:0] fl_q[$];
    int obs_rd = 0;
    int st_rd = 0;
    int fl_rd = 0;

    ro_buffer #(.ROB_ID_W(W), .XLEN(XLEN)) dut (
        .clk(clk), .rst_n(rst_n), .rdy(rdy),
        .issue_valid_from_issuer(issue_valid_from_issuer), .rd_from_issuer(rd_from_issuer),
        .is_branch_from_issuer(is_branch_from_issuer), .is_store_from_issuer(is_store_from_issuer),
        .pred_taken_from_issuer(pred_taken_from_issuer), .pc_from_issuer(pc_from_issuer),
        .dest_to_issuer(dest_to_issuer), .full_to_issuer(full_to_issuer),
        .cdb_valid(cdb_valid), .cdb_dest(cdb_dest), .cdb_value(cdb_value),
        .cdb_taken(cdb_taken), .cdb_target(cdb_target),
        .qj_from_rs(qj_from_rs), .qk_from_rs(qk_from_rs),
        .ready_j(ready_j), .ready_k(ready_k), .value_j(value_j), .value_k(value_k),
        .rd_to_reg_file(rd_to_reg_file), .dest_to_reg_file(dest_to_reg_file),
        .value_to_reg_file(value_to_reg_file),
        .store_commit_to_lsb(store_commit_to_lsb), .store_dest_to_lsb(store_dest_to_lsb),
        .reset_to_rob_bus(reset_to_rob_bus), .pc_to_fetcher(pc_to_fetcher)
    );

    always #5 clk = ~clk;

    // Monitor only records; comparisons happen in the test tasks.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rd_to_reg_file != '0)
                obs_q.push_back({rd_to_reg_file, dest_to_reg_file, value_to_reg_file});
            if (store_commit_to_lsb)
                st_q.push_back(store_dest_to_lsb);
            if (reset_to_rob_bus)
                fl_q.push_back(pc_to_fetcher);
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        rdy = 1'b1;
        issue_valid_from_issuer = 1'b0;
        is_branch_from_issuer = 1'b0;
        is_store_from_issuer = 1'b0;
        cdb_valid = 1'b0;
        qj_from_rs = '0;
        qk_from_rs = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        exp_q.delete();
        obs_rd = obs_q.size();
        st_rd = st_q.size();
        fl_rd = fl_q.size();
    endtask

    task automatic issue(input logic [4:0] rd, input logic br, input logic st, input logic pt,
                         input logic [XLEN-1:0] pc);
        issue_valid_from_issuer = 1'b1;
        rd_from_issuer = rd;
        is_branch_from_issuer = br;
        is_store_from_issuer = st;
        pred_taken_from_issuer = pt;
        pc_from_issuer = pc;
        @(negedge clk);
        issue_valid_from_issuer = 1'b0;
        is_branch_from_issuer = 1'b0;
        is_store_from_issuer = 1'b0;
    endtask

    task automatic cdb(input logic [W-1:0] tag, input logic [XLEN-1:0] val, input logic tk,
                       input logic [XLEN-1:0] tgt);
        cdb_valid = 1'b1;
        cdb_dest = tag;
        cdb_value = val;
        cdb_taken = tk;
        cdb_target = tgt;
        @(negedge clk);
        cdb_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (rd_to_reg_file !== 5'd0) begin errors++; $display("FAIL reset_rd: got %0h expected 0", rd_to_reg_file); end
        checks++; if (dest_to_reg_file !== 4'd0) begin errors++; $display("FAIL reset_dest: got %0h expected 0", dest_to_reg_file); end
        checks++; if (value_to_reg_file !== 32'd0) begin errors++; $display("FAIL reset_value: got %0h expected 0", value_to_reg_file); end
        checks++; if (store_commit_to_lsb !== 1'b0) begin errors++; $display("FAIL reset_store: got %0h expected 0", store_commit_to_lsb); end
        checks++; if (reset_to_rob_bus !== 1'b0) begin errors++; $display("FAIL reset_flush: got %0h expected 0", reset_to_rob_bus); end
        checks++; if (pc_to_fetcher !== 32'd0) begin errors++; $display("FAIL reset_pc: got %0h expected 0", pc_to_fetcher); end
        checks++; if (full_to_issuer !== 1'b0) begin errors++; $display("FAIL reset_full: got %0h expected 0", full_to_issuer); end
        checks++; if (dest_to_issuer !== 4'd1) begin errors++; $display("FAIL reset_tail: got %0h expected 1", dest_to_issuer); end
        checks++; if (ready_j !== 1'b1 || value_j !== 32'd0) begin errors++; $display("FAIL reset_lookup0: got %0h/%0h expected 1/0", ready_j, value_j); end
    endtask

    task automatic test_rdy_freeze();
        do_reset();
        rdy = 1'b0;
        issue_valid_from_issuer = 1'b1;
        rd_from_issuer = 5'd4;
        repeat (2) @(negedge clk);
        checks++; if (dest_to_issuer !== 4'd1) begin errors++; $display("FAIL rdy_hold_tail: got %0h expected 1", dest_to_issuer); end
        rdy = 1'b1;
        @(negedge clk);
        issue_valid_from_issuer = 1'b0;
        checks++; if (dest_to_issuer !== 4'd2) begin errors++; $display("FAIL rdy_resume_tail: got %0h expected 2", dest_to_issuer); end
    endtask

    task automatic test_out_of_order();
        commit_t e;
        logic [XLEN-1:0] vals [3];
        vals[0] = 32'h22; vals[1] = 32'h33; vals[2] = 32'h11;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            checks++; if (dest_to_issuer !== 4'(i + 1)) begin errors++; $display("FAIL ooo_tag%0d: got %0h expected %0h", i, dest_to_issuer, i + 1); end
            exp_q.push_back({5'(5 + i), 4'(i + 1), vals[i]});
            issue(5'(5 + i), 1'b0, 1'b0, 1'b0, 32'(i * 4));
        end
        cdb(4'd3, 32'h11, 1'b0, '0);
        cdb(4'd1, 32'h22, 1'b0, '0);
        cdb(4'd2, 32'h33, 1'b0, '0);
        for (int i = 0; i < 20 && (obs_q.size() - obs_rd) < exp_q.size(); i++) @(negedge clk);
        repeat (3) @(negedge clk);
        checks++; if (obs_q.size() - obs_rd !== exp_q.size()) begin errors++; $display("FAIL ooo_count: got %0d expected %0d", obs_q.size() - obs_rd, exp_q.size()); end
        while (exp_q.size() > 0 && obs_rd < obs_q.size()) begin
            e = exp_q.pop_front();
            checks++; if (obs_q[obs_rd] !== e) begin errors++; $display("FAIL ooo_commit: got %h expected %h", obs_q[obs_rd], e); end
            obs_rd++;
        end
    endtask

    task automatic test_full_wrap();
        commit_t e;
        do_reset();
        for (int i = 1; i <= 15; i++) issue(5'(i), 1'b0, 1'b0, 1'b0, 32'(i * 4));
        checks++; if (full_to_issuer !== 1'b1) begin errors++; $display("FAIL full_set: got %0h expected 1", full_to_issuer); end
        issue(5'd20, 1'b0, 1'b0, 1'b0, 32'h0);
        checks++; if (full_to_issuer !== 1'b1 || dest_to_issuer !== 4'd1) begin errors++; $display("FAIL full_ignore: got full %0h tail %0h expected 1/1", full_to_issuer, dest_to_issuer); end
        exp_q.push_back({5'd1, 4'd1, 32'hC0DE});
        cdb(4'd1, 32'hC0DE, 1'b0, '0);
        for (int i = 0; i < 10 && full_to_issuer; i++) @(negedge clk);
        checks++; if (full_to_issuer !== 1'b0) begin errors++; $display("FAIL full_drop: got %0h expected 0", full_to_issuer); end
        checks++; if (dest_to_issuer !== 4'd1) begin errors++; $display("FAIL wrap_tag: got %0h expected 1", dest_to_issuer); end
        issue(5'd21, 1'b0, 1'b0, 1'b0, 32'h0);
        checks++; if (full_to_issuer !== 1'b1 || dest_to_issuer !== 4'd2) begin errors++; $display("FAIL wrap_issue: got full %0h tail %0h expected 1/2", full_to_issuer, dest_to_issuer); end
        repeat (3) @(negedge clk);
        checks++; if (obs_q.size() - obs_rd !== 1) begin errors++; $display("FAIL full_commit_count: got %0d expected 1", obs_q.size() - obs_rd); end
        while (exp_q.size() > 0 && obs_rd < obs_q.size()) begin
            e = exp_q.pop_front();
            checks++; if (obs_q[obs_rd] !== e) begin errors++; $display("FAIL full_commit: got %h expected %h", obs_q[obs_rd], e); end
            obs_rd++;
        end
    endtask

    task automatic test_lookup();
        logic exp_byp;
`ifdef ROB_CDB_BYPASS_EN
        exp_byp = 1'b1;
`else
        exp_byp = 1'b0;
`endif
        do_reset();
        for (int i = 0; i < 4; i++) issue(5'(i + 1), 1'b0, 1'b0, 1'b0, 32'h0);
        qj_from_rs = 4'd4;
        qk_from_rs = 4'd0;
        cdb_valid = 1'b1; cdb_dest = 4'd4; cdb_value = 32'hAB; cdb_taken = 1'b0; cdb_target = '0;
        #1;
        checks++; if (ready_j !== exp_byp) begin errors++; $display("FAIL lookup_same_cycle: got %0h expected %0h", ready_j, exp_byp); end
        if (exp_byp) begin
            checks++; if (value_j !== 32'hAB) begin errors++; $display("FAIL lookup_bypass_val: got %0h expected ab", value_j); end
        end
        checks++; if (ready_k !== 1'b1 || value_k !== 32'd0) begin errors++; $display("FAIL lookup_tag0: got %0h/%0h expected 1/0", ready_k, value_k); end
        @(negedge clk);
        cdb_valid = 1'b0;
        qk_from_rs = 4'd2;
        #1;
        checks++; if (ready_j !== 1'b1 || value_j !== 32'hAB) begin errors++; $display("FAIL lookup_after: got %0h/%0h expected 1/ab", ready_j, value_j); end
        checks++; if (ready_k !== 1'b0) begin errors++; $display("FAIL lookup_pending: got %0h expected 0", ready_k); end
        qj_from_rs = '0;
        qk_from_rs = '0;
    endtask

    task automatic test_store();
        commit_t e;
        do_reset();
        issue(5'd0, 1'b0, 1'b1, 1'b0, 32'h20);
        exp_q.push_back({5'd3, 4'd2, 32'h77});
        issue(5'd3, 1'b0, 1'b0, 1'b0, 32'h24);
        exp_q.push_back({5'd1, 4'd3, 32'h44});
        issue(5'd1, 1'b1, 1'b0, 1'b1, 32'h40);
        cdb(4'd2, 32'h77, 1'b0, '0);
        cdb(4'd3, 32'hDEAD, 1'b1, 32'h80);
        for (int i = 0; i < 20 && (obs_q.size() - obs_rd) < exp_q.size(); i++) @(negedge clk);
        repeat (3) @(negedge clk);
        checks++; if (st_q.size() - st_rd !== 1) begin errors++; $display("FAIL store_pulses: got %0d expected 1", st_q.size() - st_rd); end
        else begin
            checks++; if (st_q[st_rd] !== 4'd1) begin errors++; $display("FAIL store_dest: got %0h expected 1", st_q[st_rd]); end
        end
        checks++; if (fl_q.size() - fl_rd !== 0) begin errors++; $display("FAIL store_no_flush: got %0d expected 0", fl_q.size() - fl_rd); end
        checks++; if (obs_q.size() - obs_rd !== exp_q.size()) begin errors++; $display("FAIL store_commit_count: got %0d expected %0d", obs_q.size() - obs_rd, exp_q.size()); end
        while (exp_q.size() > 0 && obs_rd < obs_q.size()) begin
            e = exp_q.pop_front();
            checks++; if (obs_q[obs_rd] !== e) begin errors++; $display("FAIL store_commit: got %h expected %h", obs_q[obs_rd], e); end
            obs_rd++;
        end
    endtask

    task automatic test_mispredict();
        commit_t e;
        do_reset();
        issue(5'd0, 1'b1, 1'b0, 1'b0, 32'h100);
        issue(5'd8, 1'b0, 1'b0, 1'b0, 32'h104);
        issue(5'd9, 1'b0, 1'b0, 1'b0, 32'h108);
        cdb(4'd2, 32'h99, 1'b0, '0);
        cdb(4'd3, 32'h98, 1'b0, '0);
        cdb(4'd1, 32'h0, 1'b1, 32'h200);
        for (int i = 0; i < 10 && !reset_to_rob_bus; i++) @(negedge clk);
        checks++; if (reset_to_rob_bus !== 1'b1 || pc_to_fetcher !== 32'h200) begin errors++; $display("FAIL flush_pulse: got %0h pc %0h expected 1 pc 200", reset_to_rob_bus, pc_to_fetcher); end
        @(negedge clk);
        checks++; if (reset_to_rob_bus !== 1'b0) begin errors++; $display("FAIL flush_len: got %0h expected 0", reset_to_rob_bus); end
        checks++; if (dest_to_issuer !== 4'd1 || full_to_issuer !== 1'b0) begin errors++; $display("FAIL flush_state: got tail %0h full %0h expected 1/0", dest_to_issuer, full_to_issuer); end
        repeat (2) @(negedge clk);
        checks++; if (obs_q.size() - obs_rd !== 0) begin errors++; $display("FAIL flush_no_commit: got %0d expected 0", obs_q.size() - obs_rd); end
        checks++; if (fl_q.size() - fl_rd !== 1) begin errors++; $display("FAIL flush_count: got %0d expected 1", fl_q.size() - fl_rd); end
        exp_q.push_back({5'd10, 4'd1, 32'h55});
        issue(5'd10, 1'b0, 1'b0, 1'b0, 32'h200);
        cdb(4'd1, 32'h55, 1'b0, '0);
        for (int i = 0; i < 10 && (obs_q.size() - obs_rd) < exp_q.size(); i++) @(negedge clk);
        repeat (2) @(negedge clk);
        checks++; if (obs_q.size() - obs_rd !== 1) begin errors++; $display("FAIL post_flush_count: got %0d expected 1", obs_q.size() - obs_rd); end
        while (exp_q.size() > 0 && obs_rd < obs_q.size()) begin
            e = exp_q.pop_front();
            checks++; if (obs_q[obs_rd] !== e) begin errors++; $display("FAIL post_flush_commit: got %h expected %h", obs_q[obs_rd], e); end
            obs_rd++;
        end
    endtask

    // Continues from the post-flush state so pc_to_fetcher still holds a non-zero value.
    task automatic test_async_reset();
        checks++; if (pc_to_fetcher !== 32'h200) begin errors++; $display("FAIL pre_reset_pc: got %0h expected 200", pc_to_fetcher); end
        issue(5'd11, 1'b0, 1'b0, 1'b0, 32'h0);
        issue(5'd12, 1'b0, 1'b0, 1'b0, 32'h4);
        issue(5'd13, 1'b0, 1'b0, 1'b0, 32'h8);
        cdb(4'd2, 32'h1, 1'b0, '0);
        cdb(4'd3, 32'h2, 1'b0, '0);
        cdb(4'd4, 32'h3, 1'b0, '0);
        for (int i = 0; i < 10 && rd_to_reg_file == '0; i++) @(negedge clk);
        checks++; if (rd_to_reg_file === 5'd0) begin errors++; $display("FAIL stream_active: got %0h expected nonzero", rd_to_reg_file); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (rd_to_reg_file !== 5'd0 || dest_to_reg_file !== 4'd0 || value_to_reg_file !== 32'd0) begin errors++; $display("FAIL async_commit: got %0h/%0h/%0h expected 0/0/0", rd_to_reg_file, dest_to_reg_file, value_to_reg_file); end
        checks++; if (pc_to_fetcher !== 32'd0 || reset_to_rob_bus !== 1'b0 || store_commit_to_lsb !== 1'b0) begin errors++; $display("FAIL async_pulses: got pc %0h flush %0h st %0h expected 0", pc_to_fetcher, reset_to_rob_bus, store_commit_to_lsb); end
        checks++; if (dest_to_issuer !== 4'd1 || full_to_issuer !== 1'b0) begin errors++; $display("FAIL async_ptrs: got tail %0h full %0h expected 1/0", dest_to_issuer, full_to_issuer); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #1;
        test_reset();
        test_rdy_freeze();
        test_out_of_order();
        test_full_wrap();
        test_lookup();
        test_store();
        test_mispredict();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end
endmodule
